// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART engine.
// Parity and bit-period helpers are used at elaboration and in the datapath.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [7:0] data, input parity_mode_e mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

  function automatic int bit_clks(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: expire_o is high for the single cycle in which the
// count reads 1, so a load of N yields an expiry exactly N cycles later.
module uart_bit_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/uart_engine.sv
// Full-duplex UART with configurable data width, parity and stop bits.
// TX and RX are independent FSMs, each paced by its own bit timer.
module uart_engine
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 1000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_data,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 donetx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 donerx,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int BIT_CLKS  = bit_clks(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CNT_W     = $clog2(BIT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CLKS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CLKS);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam parity_mode_e PMODE = parity_mode_e'(PARITY_MODE[1:0]);
  localparam bit PAR_EN = (PARITY_MODE != 0);

  if (BIT_CLKS < 4 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY_MODE < 0 ||
      PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_engine: illegal parameter combination");
  end

  // ---------------- transmit ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic                 tx_stop2_q, tx_stop2_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 donetx_q, donetx_d;
  logic                 tx_load, tx_expire;

  uart_bit_timer #(.WIDTH(CNT_W)) u_tx_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tx_load),
    .load_val_i(BIT_LOAD),
    .expire_o  (tx_expire)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_stop2_d = tx_stop2_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    donetx_d   = 1'b0;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (new_data) begin
          tx_shift_d = din;
          tx_par_d   = calc_parity(8'(din), PMODE);
          tx_d       = 1'b0;
          tx_load    = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_expire) begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = 3'd0;
          tx_load    = 1'b1;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_expire) begin
          tx_load = 1'b1;
          if (tx_bit_q == LAST_BIT) begin
            tx_stop2_d = 1'b0;
            if (PAR_EN) begin
              tx_d       = tx_par_q;
              tx_state_d = TX_PARITY;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_expire) begin
          tx_d       = 1'b1;
          tx_load    = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_expire) begin
          if (STOP_BITS == 2 && !tx_stop2_q) begin
            tx_stop2_d = 1'b1;
            tx_load    = 1'b1;
          end else begin
            tx_d       = 1'b1;
            donetx_d   = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_stop2_q <= 1'b0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      donetx_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop2_q <= tx_stop2_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      donetx_q   <= donetx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != TX_IDLE);
  assign donetx  = donetx_q;

  // ---------------- receive ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 donerx_q, donerx_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_load, rx_expire;
  logic [CNT_W-1:0]     rx_load_val;

  uart_bit_timer #(.WIDTH(CNT_W)) u_rx_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (rx_load),
    .load_val_i(rx_load_val),
    .expire_o  (rx_expire)
  );

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_shift_d  = rx_shift_q;
    rx_bit_d    = rx_bit_q;
    rx_par_d    = rx_par_q;
    dout_d      = dout_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    donerx_d    = 1'b0;
    rx_load     = 1'b0;
    rx_load_val = BIT_LOAD;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          rx_load     = 1'b1;
          rx_load_val = HALF_LOAD;
          rx_state_d  = RX_START;
        end
      end
      RX_START: begin
        if (rx_expire) begin
          if (rx_s_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_load    = 1'b1;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_expire) begin
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
          rx_load    = 1'b1;
          if (rx_bit_q == LAST_BIT) begin
            rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_expire) begin
          rx_par_d   = rx_s_q;
          rx_load    = 1'b1;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_expire) begin
          donerx_d   = 1'b1;
          dout_d     = rx_shift_q;
          perr_d     = PAR_EN && (rx_par_q != calc_parity(8'(rx_shift_q), PMODE));
          ferr_d     = !rx_s_q;
          rx_state_d = rx_s_q ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        // A stuck-low line must rise before another start can be seen.
        if (rx_s_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_par_q   <= 1'b0;
      dout_q     <= '0;
      donerx_q   <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_par_q   <= rx_par_d;
      dout_q     <= dout_d;
      donerx_q   <= donerx_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign dout       = dout_q;
  assign donerx     = donerx_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_engine.sv
// Scoreboard bench: stimulus queues expected TX line patterns and RX frames;
// negedge monitors compare whenever the DUTs present output.
module tb_uart_engine;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         due;
  } rx_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // dut_a: 8N1, rx driven by the bench
  logic       new_data_a = 1'b0;
  logic [7:0] din_a = 8'h00;
  logic       tx_a, busy_a, donetx_a, donerx_a, perr_a, ferr_a;
  logic       rx_a = 1'b1;
  logic [7:0] dout_a;

  // dut_b: 7E2, tx looped back to rx
  logic       new_data_b = 1'b0;
  logic [6:0] din_b = 7'h00;
  logic       tx_b, busy_b, donetx_b, donerx_b, perr_b, ferr_b;
  logic [6:0] dout_b;

  // dut_c: 8E1, rx driven by the bench
  logic       tx_c, busy_c, donetx_c, donerx_c, perr_c, ferr_c;
  logic       rx_c = 1'b1;
  logic [7:0] dout_c;

  uart_engine #(.CLK_FREQ(160000), .BAUD_RATE(10000), .DATA_BITS(8),
                .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .new_data(new_data_a), .din(din_a), .tx(tx_a),
    .tx_busy(busy_a), .donetx(donetx_a), .rx(rx_a), .dout(dout_a),
    .donerx(donerx_a), .parity_err(perr_a), .frame_err(ferr_a));

  uart_engine #(.CLK_FREQ(160000), .BAUD_RATE(10000), .DATA_BITS(7),
                .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .new_data(new_data_b), .din(din_b), .tx(tx_b),
    .tx_busy(busy_b), .donetx(donetx_b), .rx(tx_b), .dout(dout_b),
    .donerx(donerx_b), .parity_err(perr_b), .frame_err(ferr_b));

  uart_engine #(.CLK_FREQ(160000), .BAUD_RATE(10000), .DATA_BITS(8),
                .PARITY_MODE(1), .STOP_BITS(1)) dut_c (
    .clk(clk), .rst(rst), .new_data(1'b0), .din(8'h00), .tx(tx_c),
    .tx_busy(busy_c), .donetx(donetx_c), .rx(rx_c), .dout(dout_c),
    .donerx(donerx_c), .parity_err(perr_c), .frame_err(ferr_c));

  rx_exp_t     exp_rx_a[$];
  rx_exp_t     exp_rx_b[$];
  rx_exp_t     exp_rx_c[$];
  logic [15:0] exp_tx_a[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic check_near(input string nm, input int act, input int exp, input int tol);
    n_total++;
    if (act >= exp - tol && act <= exp + tol) n_pass++;
    else $display("FAIL %s: got cycle %0d, expected %0d +/- %0d", nm, act, exp, tol);
  endtask

  task automatic rx_compare(input string nm, input rx_exp_t e, input logic [7:0] d,
                            input logic pe, input logic fe);
    $display("%s frame: dout=0x%02h perr=%0b ferr=%0b at cycle %0d", nm, d, pe, fe, cyc);
    check({nm, " dout"}, 32'(d), 32'(e.data));
    check({nm, " parity_err"}, 32'(pe), 32'(e.perr));
    check({nm, " frame_err"}, 32'(fe), 32'(e.ferr));
    check_near({nm, " latency"}, cyc, e.due, 2);
  endtask

  // RX scoreboard monitors
  always @(negedge clk) begin
    if (donerx_a) begin
      check("rx_a frame pending", 32'(exp_rx_a.size() != 0), 32'd1);
      if (exp_rx_a.size() != 0) rx_compare("rx_a", exp_rx_a.pop_front(), dout_a, perr_a, ferr_a);
    end
    if (donerx_b) begin
      check("rx_b frame pending", 32'(exp_rx_b.size() != 0), 32'd1);
      if (exp_rx_b.size() != 0) rx_compare("rx_b", exp_rx_b.pop_front(), 8'(dout_b), perr_b, ferr_b);
    end
    if (donerx_c) begin
      check("rx_c frame pending", 32'(exp_rx_c.size() != 0), 32'd1);
      if (exp_rx_c.size() != 0) rx_compare("rx_c", exp_rx_c.pop_front(), dout_c, perr_c, ferr_c);
    end
  end

  // TX monitor for dut_a: every cycle of a frame must show the expected line bit
  int          tx_off = -1;
  logic [15:0] tx_bits = '0;
  always @(negedge clk) begin
    if (tx_off < 0 && busy_a) begin
      check("tx_a frame pending", 32'(exp_tx_a.size() != 0), 32'd1);
      if (exp_tx_a.size() != 0) begin
        tx_bits = exp_tx_a.pop_front();
        tx_off  = 0;
      end
    end
    if (tx_off >= 0) begin
      if (rst_seen) begin
        $display("tx_a frame abandoned by reset at offset %0d", tx_off);
        check("tx_a after reset {tx,busy,done}", 32'({tx_a, busy_a, donetx_a}), 32'b100);
        tx_off = -1;
      end else if (tx_off < 160) begin
        check($sformatf("tx_a offset %0d {tx,busy,done}", tx_off),
              32'({tx_a, busy_a, donetx_a}), 32'({tx_bits[tx_off/16], 2'b10}));
        tx_off++;
      end else begin
        $display("tx_a frame complete at cycle %0d", cyc);
        check("tx_a end {tx,busy,done}", 32'({tx_a, busy_a, donetx_a}), 32'b101);
        tx_off = -1;
      end
    end else if (donetx_a) begin
      check("donetx_a unexpected", 32'(donetx_a), 32'd0);
    end
  end

  // Drive a bit sequence (bit 0 first) onto rx_a (ln=0) or rx_c (ln=1).
  task automatic send_rx(input int ln, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (ln == 0) rx_a = bits[i];
      else rx_c = bits[i];
      repeat (16) @(negedge clk);
    end
    if (ln == 0) rx_a = 1'b1;
    else rx_c = 1'b1;
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("reset tx_a", 32'(tx_a), 32'd1);
    check("reset {busy,donetx,donerx,perr,ferr}_a",
          32'({busy_a, donetx_a, donerx_a, perr_a, ferr_a}), 32'd0);
    check("reset dout_a", 32'(dout_a), 32'd0);
    check("reset tx_b", 32'(tx_b), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1; new_data at cycle 50 ignored
    exp_tx_a.push_back(16'h034A);
    din_a = 8'hA5; new_data_a = 1'b1;
    @(negedge clk);
    new_data_a = 1'b0;
    repeat (49) @(negedge clk);
    din_a = 8'hFF; new_data_a = 1'b1;
    @(negedge clk);
    new_data_a = 1'b0;
    repeat (130) @(negedge clk);

    // 7E2 loopback 0x35 (parity 0), then 0x4A (parity 1) back-to-back
    exp_rx_b.push_back('{8'h35, 1'b0, 1'b0, cyc + 1 + 154});
    din_b = 7'h35; new_data_b = 1'b1;
    @(negedge clk);
    new_data_b = 1'b0;
    w = 0;
    while (!donetx_b && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("donetx_b seen", 32'(donetx_b), 32'd1);
    exp_rx_b.push_back('{8'h4A, 1'b0, 1'b0, cyc + 1 + 154});
    din_b = 7'h4A; new_data_b = 1'b1;
    @(negedge clk);
    new_data_b = 1'b0;
    repeat (200) @(negedge clk);

    // 8E1 0x0F with wrong parity bit 1
    exp_rx_c.push_back('{8'h0F, 1'b1, 1'b0, cyc + 1 + 170});
    send_rx(1, {5'b0, 1'b1, 1'b1, 8'h0F, 1'b0}, 11);
    repeat (20) @(negedge clk);

    // rx_a held low for 20 bit periods: one frame of zeros with frame_err
    exp_rx_a.push_back('{8'h00, 1'b0, 1'b1, cyc + 1 + 154});
    rx_a = 1'b0;
    repeat (320) @(negedge clk);
    rx_a = 1'b1;
    repeat (32) @(negedge clk);
    check("dout_a held after break", 32'(dout_a), 32'd0);
    check("frame_err_a held after break", 32'(ferr_a), 32'd1);
    exp_rx_a.push_back('{8'h5A, 1'b0, 1'b0, cyc + 1 + 154});
    send_rx(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
    repeat (20) @(negedge clk);

    // 4-cycle glitch is a false start; the following 0x3C frame is received
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (30) @(negedge clk);
    exp_rx_a.push_back('{8'h3C, 1'b0, 1'b0, cyc + 1 + 154});
    send_rx(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (20) @(negedge clk);

    // Reset at cycle 70 of a TX frame, then a clean 0x81 frame
    exp_tx_a.push_back(16'h0266);
    din_a = 8'h33; new_data_a = 1'b1;
    @(negedge clk);
    new_data_a = 1'b0;
    repeat (69) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    exp_tx_a.push_back(16'h0302);
    din_a = 8'h81; new_data_a = 1'b1;
    @(negedge clk);
    new_data_a = 1'b0;
    repeat (180) @(negedge clk);

    check("rx_a frames outstanding", 32'(exp_rx_a.size()), 32'd0);
    check("rx_b frames outstanding", 32'(exp_rx_b.size()), 32'd0);
    check("rx_c frames outstanding", 32'(exp_rx_c.size()), 32'd0);
    check("tx_a frames outstanding", 32'(exp_tx_a.size()), 32'd0);
    check("tx_a monitor idle", 32'(tx_off), 32'hFFFF_FFFF);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
